// File: rtl/alu_cmd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_issuer
//  Description : Queues ALU commands in a small FIFO and issues them one at a
//                time to an external single-cycle ALU. Each command produces
//                exactly one response. The response carries the ALU result, or
//                an error if the opcode is unsupported or the ALU never
//                completes within the timeout window.
//
//  Ports
//    clk          : single clock, rising-edge
//    reset_n      : asynchronous active-low reset
//    cmd_valid    : command request valid
//    cmd_a/cmd_b  : 8-bit operands
//    cmd_op       : 3-bit opcode (001, 010, 011 are issued; others are errors)
//    cmd_ready    : FIFO has room (not full)
//    A/B/op       : operands/opcode driven to the ALU
//    start        : one-cycle issue pulse to the ALU
//    done_aax     : ALU completion (honoured only while waiting)
//    result_aax   : 16-bit ALU result
//    rsp_valid    : response available
//    rsp_ready    : response consumer ready
//    rsp_result   : response result
//    rsp_op       : opcode of the command being answered
//    rsp_err      : response error flag
//    busy         : an operation is in progress or commands are queued
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    // command request
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic        cmd_ready,
    // ALU side
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [2:0]  op,
    output logic        start,
    input  logic        done_aax,
    input  logic [15:0] result_aax,
    // response
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    // status
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_entry_w = 8 + 8 + 3;

    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    // The ALU gets four WAIT cycles to answer; the counter reaches this value
    // during the fourth one.
    localparam logic [2:0] c_tmo_last = 3'd3;

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------------
    // Command FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_entry_w-1:0] w_head;
    logic [7:0]           w_head_a;
    logic [7:0]           w_head_b;
    logic [2:0]           w_head_op;
    logic                 w_head_op_ok;

    assign w_full    = (r_count == c_full_cnt);
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    // The head is consumed only when the FSM is free to take it.
    assign w_pop     = (r_state == S_IDLE) && !w_empty;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_a  = w_head[18:11];
    assign w_head_b  = w_head[10:3];
    assign w_head_op = w_head[2:0];

    // Only add/and/xor-class opcodes are forwarded to the ALU.
    assign w_head_op_ok = (w_head_op == 3'b001) ||
                          (w_head_op == 3'b010) ||
                          (w_head_op == 3'b011);

    // Storage has no reset: contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Issue / response FSM with registered outputs
    // ------------------------------------------------------------------------
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [2:0]  r_op;
    logic        r_start;
    logic [2:0]  r_tmo;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_result;
    logic [2:0]  r_rsp_op;
    logic        r_rsp_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_start      <= 1'b0;
            r_tmo        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_op     <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            // start is a single-cycle pulse; only the IDLE->ISSUE transition
            // raises it.
            r_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        // rsp_op records the opcode of whatever was popped,
                        // valid or not, so error responses still identify it.
                        r_rsp_op <= w_head_op;
                        if (w_head_op_ok) begin
                            r_a     <= w_head_a;
                            r_b     <= w_head_b;
                            r_op    <= w_head_op;
                            r_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            // Unsupported opcode: answer immediately with an
                            // error and never disturb the ALU.
                            r_rsp_result <= '0;
                            r_rsp_err    <= 1'b1;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end
                end

                S_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (done_aax) begin
                        // Result is forwarded untouched, including any
                        // zero-extension the ALU applied.
                        r_rsp_result <= result_aax;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_HOLD;
                    end else if (r_tmo == c_tmo_last) begin
                        r_rsp_result <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_HOLD;
                    end else begin
                        r_tmo <= r_tmo + 3'd1;
                    end
                end

                S_HOLD: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign cmd_ready  = !w_full;
    assign A          = r_a;
    assign B          = r_b;
    assign op         = r_op;
    assign start      = r_start;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_op     = r_rsp_op;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_issuer
//  Description : Self-checking bench for alu_cmd_issuer. A behavioural ALU
//                answers one cycle after start (or never, when muted).
//                Expected responses are queued as commands are driven and
//                compared in order as responses are handshaken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic        cmd_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done_aax = 1'b0;
    logic [15:0] result_aax = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .A          (A),
        .B          (B),
        .op         (op),
        .start      (start),
        .done_aax   (done_aax),
        .result_aax (result_aax),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [15:0] res;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        err;
        logic [2:0]  op;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[9];

    int n_checks  = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int sc        = 0;
    int n         = 0;

    logic       alu_en = 1'b1;
    logic       inject = 1'b0;
    logic       pending = 1'b0;
    logic       prev_start = 1'b0;
    logic [7:0] pa = '0;
    logic [7:0] pb = '0;
    logic [2:0] pop_code = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU behaviour: add / and / xor, results zero-extended.
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] o);
        case (o)
            3'b001:  alu_fn = {8'h00, a} + {8'h00, b};
            3'b010:  alu_fn = {8'h00, a & b};
            3'b011:  alu_fn = {8'h00, a ^ b};
            default: alu_fn = 16'h0000;
        endcase
    endfunction

    // ALU model: done one cycle after the start pulse.
    always @(posedge clk) begin
        #2;
        done_aax   = 1'b0;
        result_aax = 16'h0000;
        if (!reset_n) begin
            pending    = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (inject) begin
                done_aax   = 1'b1;
                result_aax = 16'hBEEF;
            end
            if (pending) begin
                done_aax   = 1'b1;
                result_aax = alu_fn(pa, pb, pop_code);
                pending    = 1'b0;
            end
            if (start) begin
                start_cnt++;
                chk("start_one_cycle", {31'b0, prev_start}, 32'd0);
                if (alu_en) begin
                    pending  = 1'b1;
                    pa       = A;
                    pb       = B;
                    pop_code = op;
                end
            end
            prev_start = start;
        end
    end

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got result 0x%0h op %0d err %0b, required no response",
                         rsp_result, rsp_op, rsp_err);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_result", {16'h0, rsp_result}, {16'h0, mon_e.res});
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
                chk("rsp_op", {29'b0, rsp_op}, {29'b0, mon_e.op});
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic push(input vec_t v);
        int g;
        g = 0;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_op    = v.op;
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        n_checks++;
        if (g >= 100) begin
            n_fail++;
            $display("FAIL push_timeout: got cmd_ready 0 for %0d cycles, required acceptance", g);
        end else begin
            sb_q.push_back('{v.res, v.err, v.op});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb_q.size() != 0 || busy) && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        n_checks++;
        if (g >= 300) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses busy %0b, required 0 and 0",
                     sb_q.size(), busy);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_start"}, {31'b0, start}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_result"}, {16'h0, rsp_result}, 32'd0);
        chk({tag, "_rsp_op"}, {29'b0, rsp_op}, 32'd0);
        chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
        chk({tag, "_A"}, {24'h0, A}, 32'd0);
        chk({tag, "_B"}, {24'h0, B}, 32'd0);
        chk({tag, "_op"}, {29'b0, op}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0};
        vecs[1] = '{8'hAA, 8'h55, 3'b011, 16'h00FF, 1'b0};
        vecs[2] = '{8'h03, 8'h04, 3'b001, 16'h0007, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 3'b001, 16'h0000, 1'b0};
        vecs[4] = '{8'hFF, 8'h0F, 3'b010, 16'h000F, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 3'b000, 16'h0000, 1'b1};
        vecs[6] = '{8'h56, 8'h78, 3'b101, 16'h0000, 1'b1};
        vecs[7] = '{8'h80, 8'h80, 3'b001, 16'h0100, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 3'b011, 16'h0000, 1'b0};

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- single add, exact latency ----------------
        sc        = start_cnt;
        cmd_a     = 8'hFF;
        cmd_b     = 8'h01;
        cmd_op    = 3'b001;
        cmd_valid = 1'b1;
        sb_q.push_back('{16'h0100, 1'b0, 3'b001});
        @(negedge clk);
        chk("lat_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;                 // after E0
        cmd_valid = 1'b0;
        chk("lat_e0_start", {31'b0, start}, 32'd0);
        chk("lat_e0_busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;                 // after E1
        chk("lat_e1_start", {31'b0, start}, 32'd1);
        chk("lat_e1_A", {24'h0, A}, 32'h0000_00FF);
        chk("lat_e1_B", {24'h0, B}, 32'h0000_0001);
        chk("lat_e1_op", {29'b0, op}, 32'd1);
        @(posedge clk); #1;                 // after E2
        chk("lat_e2_start", {31'b0, start}, 32'd0);
        chk("lat_e2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("lat_e2_A_held", {24'h0, A}, 32'h0000_00FF);
        @(posedge clk); #1;                 // after E3
        chk("lat_e3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("lat_e3_rsp_result", {16'h0, rsp_result}, 32'h0000_0100);
        drain();
        chk("lat_start_count", start_cnt - sc, 32'd1);

        // ---------------- ordering, full FIFO, backpressure ----------------
        rsp_ready = 1'b0;
        sc        = start_cnt;
        for (int i = 0; i < 5; i++) begin
            push(vecs[i]);
        end
        chk("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("full_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rsp_result", {16'h0, rsp_result}, 32'h0000_0030);
            chk("bp_rsp_op", {29'b0, rsp_op}, 32'd2);
            chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        end
        chk("bp_start_count", start_cnt - sc, 32'd1);
        rsp_ready = 1'b1;
        drain();
        chk("order_start_count", start_cnt - sc, 32'd5);

        // ---------------- invalid opcodes ----------------
        sc = start_cnt;
        push(vecs[5]);
        push(vecs[6]);
        drain();
        chk("invalid_no_start", start_cnt - sc, 32'd0);

        // ---------------- back-to-back valid ----------------
        push(vecs[7]);
        push(vecs[8]);
        drain();

        // ---------------- timeout ----------------
        alu_en = 1'b0;
        sc     = start_cnt;
        push('{8'h12, 8'h34, 3'b001, 16'h0000, 1'b1});
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_latency", n, 32'd6);
        chk("tmo_rsp_err", {31'b0, rsp_err}, 32'd1);
        chk("tmo_rsp_result", {16'h0, rsp_result}, 32'd0);
        drain();
        chk("tmo_start_count", start_cnt - sc, 32'd1);

        // ---------------- reset while waiting ----------------
        push('{8'h05, 8'h06, 3'b001, 16'h000B, 1'b0});
        push('{8'h07, 8'h08, 3'b001, 16'h000F, 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        chk_reset_outputs("rst_async");
        @(posedge clk); #1;
        reset_n = 1'b1;
        alu_en  = 1'b1;
        inject  = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("rst_post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rst_post_busy", {31'b0, busy}, 32'd0);
            chk("rst_post_start", {31'b0, start}, 32'd0);
        end
        chk_reset_outputs("rst_post");

        // ---------------- first push right after reset release ----------------
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        cmd_a     = 8'h21;
        cmd_b     = 8'h12;
        cmd_op    = 3'b011;
        cmd_valid = 1'b1;
        chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        sb_q.push_back('{16'h0033, 1'b0, 3'b011});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rel_accepted_busy", {31'b0, busy}, 32'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid in 1, cmd_a in 8, cmd_b in 8, cmd_op in 3: command request.
REQ-005 SHALL have port cmd_ready  output  1  FIFO can accept; equals not-full.
REQ-006 SHALL have ports A out 8, B out 8, op out 3: operands/opcode driven to the single-cycle ALU.
REQ-007 SHALL have port start  output  1  one-cycle issue pulse to the ALU.
REQ-008 SHALL have ports done_aax in 1, result_aax in 16: completion and result from the ALU.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-010 SHALL have ports rsp_result out 16, rsp_op out 3, rsp_err out 1: response payload.
REQ-011 SHALL have port busy  output  1  high when state != IDLE or FIFO non-empty.

Function
REQ-012 SHALL push {cmd_a,cmd_b,cmd_op} on an edge where cmd_valid && cmd_ready; FIFO full blocks push (cmd_ready=0), no overwrite.
REQ-013 SHALL support simultaneous push and pop in one edge, count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-015 IDLE, FIFO non-empty: pop head into issue register; op in {001,010,011} -> ISSUE; any other op -> HOLD with rsp_result=0, rsp_err=1, no start.
REQ-016 ISSUE: start=1 for exactly one cycle with A/B/op from issue register; next edge -> WAIT; timeout counter cleared.
REQ-017 A/B/op SHALL hold issue-register values from ISSUE until leaving WAIT; start=0 in all states other than ISSUE.
REQ-018 WAIT, done_aax=1: capture result_aax into rsp_result, rsp_err=0, -> HOLD.
REQ-019 WAIT, done_aax=0: increment 3-bit timeout counter; on 4th consecutive WAIT cycle without done -> HOLD, rsp_result=0, rsp_err=1.
REQ-020 done_aax outside WAIT SHALL be ignored.
REQ-021 HOLD: rsp_valid=1, payload stable (rsp_op = issued op); on rsp_valid && rsp_ready -> IDLE; rsp_valid low in all other states.
REQ-022 Latency: command accepted at edge E0 into empty FIFO with idle FSM, rsp_ready=1 -> ISSUE after E1, start high E1-E2, rsp_valid high after E3.
REQ-023 rsp_result width 16; 8-bit ALU results arrive zero-extended and SHALL pass unmodified.
REQ-024 Back-to-back commands SHALL be processed strictly in acceptance order, one outstanding ALU operation at most.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, FIFO empty, pointers/count/timeout 0, start=0, rsp_valid=0, rsp_err=0, rsp_result=0, rsp_op=0, A=B=0, op=0, busy=0, cmd_ready=1.
REQ-026 Reset mid-operation SHALL discard queued and in-flight commands; no response after release; late done_aax ignored.
REQ-027 After reset_n rises, first push SHALL be accepted on the next rising edge.

Verification
REQ-028 Single add: push A=8'hFF,B=8'h01,op=001, ALU model done one cycle after start -> one start pulse, rsp_result=16'h0100, rsp_err=0, rsp_valid after E3.
REQ-029 Ordering/full: push 5 commands (AND 0xF0&0x3C, XOR 0xAA^0x55, ADD 3+4, ADD 0+0, AND 0xFF&0x0F) with rsp_ready=0 -> cmd_ready low at count 4, then responses 0x0030, 0x00FF, 0x0007, 0x0000, 0x000F in order.
REQ-030 Invalid op: push op=000 then op=101 -> no start pulse, two responses rsp_result=0, rsp_err=1, rsp_op=000 then 101.
REQ-031 Timeout: ALU model never asserts done -> start once, rsp_valid after 4 WAIT cycles, rsp_err=1, rsp_result=0.
REQ-032 Backpressure: rsp_ready low 10 cycles in HOLD -> payload stable, no further start, FIFO keeps accepting until full.
REQ-033 Reset in WAIT: assert reset_n low mid-op, then done_aax pulse after release -> all outputs reset values, no rsp_valid, busy=0.
